// File: rtl/stoch_ctrl_pkg.sv
// Shared types and helpers for stochastic-computing job controllers.
// STOCH_SUB_CTRL_ABORT_EN adds the CLEAR_ABORT state to the FSM enum.
package stoch_ctrl_pkg;

  localparam int unsigned LFSR_W = 16;
  // Fibonacci taps 16,14,13,11 (1-based) -> bits 15,13,12,10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

  localparam int unsigned MAX_WIDTH = 9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FLUSH = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
`ifdef STOCH_SUB_CTRL_ABORT_EN
    , ST_CLEAR_ABORT = 3'd5
`endif
  } state_t;

  typedef struct packed {
    logic                 neg;
    logic [MAX_WIDTH-1:0] mag;
  } sign_mag_t;

  // x is sign-extended to MAX_WIDTH; magnitude clamps to 2^(width-1)-1
  function automatic sign_mag_t to_sign_mag(input logic [MAX_WIDTH-1:0] x,
                                            input int unsigned width);
    sign_mag_t            r;
    logic [MAX_WIDTH:0]   limit;
    r.neg = x[MAX_WIDTH-1];
    r.mag = r.neg ? (~x + MAX_WIDTH'(1)) : x;
    limit = (MAX_WIDTH+1)'((1 << (width - 1)) - 1);
    if ({1'b0, r.mag} > limit) begin
      r.mag = limit[MAX_WIDTH-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/stoch_signed_sub_ctrl_if.sv
// Operand request / result response handshake bundle for stoch_signed_sub_ctrl.
interface stoch_signed_sub_ctrl_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LOG_WINDOW = 8
) ();

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] a;
  logic signed [WIDTH-1:0] b;
  logic                    out_valid;
  logic                    out_ready;
  logic [LOG_WINDOW+1:0]   result;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result
  );

endinterface

// File: rtl/stoch_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous reload; shared random source for
// stochastic controllers.
module stoch_lfsr16
  import stoch_ctrl_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = LFSR_DEFAULT_SEED
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              load,
  input  logic              en,
  output logic [LFSR_W-1:0] value
);

  logic fb_c;

  assign fb_c = ^(value & LFSR_TAPS);

  // load wins over advance so a job always starts from SEED
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      value <= SEED;
    end else if (load) begin
      value <= SEED;
    end else if (en) begin
      value <= {value[LFSR_W-2:0], fb_c};
    end
  end

endmodule

// File: rtl/stoch_signed_sub_ctrl.sv
// Job sequencer for a signed p/m-channel stochastic subtractor datapath.
// Optional STOCH_SUB_CTRL_ABORT_EN adds an abort input and CLEAR_ABORT state.
module stoch_signed_sub_ctrl
  import stoch_ctrl_pkg::*;
#(
  parameter int unsigned       WIDTH        = 8,
  parameter int unsigned       LOG_WINDOW   = 8,
  parameter int unsigned       FLUSH_CYCLES = 4,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = LFSR_DEFAULT_SEED
) (
  input  logic                    CLK,
  input  logic                    nRST,
  stoch_signed_sub_ctrl_if.slave  bus,
  output logic                    dp_nrst,
  output logic                    a_p,
  output logic                    a_m,
  output logic                    b_p,
  output logic                    b_m,
  input  logic                    y_p,
  input  logic                    y_m
`ifdef STOCH_SUB_CTRL_ABORT_EN
  ,
  input  logic                    abort
`endif
);

  localparam int unsigned ACC_W      = LOG_WINDOW + 2;
  localparam int unsigned FLUSH_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int unsigned CNT_W      = (LOG_WINDOW > FLUSH_W) ? LOG_WINDOW : FLUSH_W;
  localparam int unsigned RUN_LAST   = (1 << LOG_WINDOW) - 1;
  localparam int unsigned FLUSH_LAST = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;
  localparam int unsigned R_A_MASK   = (1 << (WIDTH - 1)) - 1;
  localparam int unsigned R_B_SHIFT  = 17 - WIDTH;

  state_t              state;
  state_t              next_state;
  logic                clear_next_c;
  logic                stream_next_c;
  logic                accept_c;

  logic [CNT_W-1:0]    cnt;
  sign_mag_t           a_sm;
  sign_mag_t           b_sm;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_nx_c;
  logic [ACC_W-1:0]    result_q;
  logic                in_ready_q;
  logic                out_valid_q;

  logic [LFSR_W-1:0]   lfsr;
  logic [LFSR_W-1:0]   r_a_c;
  logic [LFSR_W-1:0]   r_b_c;
  logic                bit_a_c;
  logic                bit_b_c;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

  assign accept_c = bus.in_valid & in_ready_q;

  // State register
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; abort overrides every busy state
  always_comb begin
    next_state    = state;
    clear_next_c  = 1'b0;
    stream_next_c = 1'b0;
    unique case (state)
      ST_IDLE:  if (accept_c) next_state = ST_CLEAR;
      ST_CLEAR: next_state = (FLUSH_CYCLES == 0) ? ST_RUN : ST_FLUSH;
      ST_FLUSH: if (cnt == CNT_W'(FLUSH_LAST)) next_state = ST_RUN;
      ST_RUN:   if (cnt == CNT_W'(RUN_LAST)) next_state = ST_DONE;
      ST_DONE:  if (bus.out_ready) next_state = ST_IDLE;
`ifdef STOCH_SUB_CTRL_ABORT_EN
      ST_CLEAR_ABORT: next_state = ST_IDLE;
`endif
      default:  next_state = ST_IDLE;
    endcase
`ifdef STOCH_SUB_CTRL_ABORT_EN
    if (abort && (state != ST_IDLE) && (state != ST_CLEAR_ABORT)) begin
      next_state = ST_CLEAR_ABORT;
    end
    clear_next_c = (next_state == ST_CLEAR) || (next_state == ST_CLEAR_ABORT);
`else
    clear_next_c = (next_state == ST_CLEAR);
`endif
    stream_next_c = (next_state == ST_FLUSH) || (next_state == ST_RUN);
  end

  stoch_lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .CLK   (CLK),
    .nRST  (nRST),
    .load  (next_state == ST_CLEAR),
    .en    (stream_next_c),
    .value (lfsr)
  );

  // rA = LFSR[WIDTH-2:0], rB = LFSR[15:17-WIDTH]
  assign r_a_c   = lfsr & LFSR_W'(R_A_MASK);
  assign r_b_c   = lfsr >> R_B_SHIFT;
  assign bit_a_c = LFSR_W'(a_sm.mag) > r_a_c;
  assign bit_b_c = LFSR_W'(b_sm.mag) > r_b_c;

  always_comb begin
    acc_nx_c = acc;
    if (y_p & ~y_m) begin
      acc_nx_c = acc + ACC_W'(1);
    end else if (y_m & ~y_p) begin
      acc_nx_c = acc - ACC_W'(1);
    end
  end

  // Datapath, counters and registered outputs, all keyed off next_state
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt         <= '0;
      a_sm        <= '0;
      b_sm        <= '0;
      acc         <= '0;
      result_q    <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      dp_nrst     <= 1'b0;
      a_p         <= 1'b0;
      a_m         <= 1'b0;
      b_p         <= 1'b0;
      b_m         <= 1'b0;
    end else begin
      cnt <= (next_state != state) ? '0 : cnt + CNT_W'(1);

      if (accept_c) begin
        a_sm <= to_sign_mag(MAX_WIDTH'(bus.a), WIDTH);
        b_sm <= to_sign_mag(MAX_WIDTH'(bus.b), WIDTH);
      end

      acc <= (state == ST_RUN) ? acc_nx_c : '0;
      if ((state == ST_RUN) && (next_state == ST_DONE)) begin
        result_q <= acc_nx_c;
      end

      in_ready_q  <= (next_state == ST_IDLE);
      out_valid_q <= (next_state == ST_DONE);
      dp_nrst     <= ~clear_next_c;

      a_p <= stream_next_c & ~a_sm.neg & bit_a_c;
      a_m <= stream_next_c &  a_sm.neg & bit_a_c;
      b_p <= stream_next_c & ~b_sm.neg & bit_b_c;
      b_m <= stream_next_c &  b_sm.neg & bit_b_c;
    end
  end

endmodule

// File: doc/stoch_signed_sub_ctrl.md
Name: stoch_signed_sub_ctrl

Overview:
- Job sequencer for a signed two-channel stochastic subtractor datapath (p/m channels per operand, COUNTER_SIZE-parameterised internals).
- Accepts two signed binary operands over a valid/ready handshake and converts them to sign-split bitstreams with an on-block LFSR number generator.
- Clears and warms up the datapath, then integrates the y_p/y_m output streams over a fixed window.
- Returns a signed binary count over a second valid/ready handshake. Sits between binary control logic and one subtractor instance.

Parameters:
- WIDTH, 8, operand width in two's complement; legal range 2..9.
- LOG_WINDOW, 8, integration window is 2^LOG_WINDOW cycles.
- FLUSH_CYCLES, 4, warm-up cycles after datapath clear; streams are driven but not counted. 0 is legal.
- LFSR_SEED, 16'hACE1, nonzero LFSR load value.

Ports:
- CLK  in  1  clock.
- nRST  in  1  synchronous active-low reset.
- in_valid  in  1  operand request.
- in_ready  out  1  high only in IDLE.
- a  in  WIDTH  signed minuend.
- b  in  WIDTH  signed subtrahend.
- dp_nrst  out  1  synchronous active-low clear to the datapath.
- a_p, a_m, b_p, b_m  out  1 each  operand streams to the datapath.
- y_p, y_m  in  1 each  datapath output streams.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  LOG_WINDOW+2  signed, raw (y_p - y_m) count.

Behaviour:
- Reset: on CLK edge with nRST=0 the following values are loaded:
  - FSM=IDLE, LFSR=LFSR_SEED, accumulator=0.
  - in_ready=1, out_valid=0, result=0.
  - all streams=0, dp_nrst=0 while nRST=0.
- Operand capture: when in_valid&in_ready, latch sign and magnitude of a and b.
  - mag = |x|; the most negative value clamps to 2^(WIDTH-1)-1.
  - Zero operand has both channels silent.
- FSM:
  - IDLE: accept on in_valid&in_ready -> CLEAR.
  - CLEAR: 1 cycle. dp_nrst=0, LFSR reloaded with seed, accumulator=0, streams=0 -> FLUSH, or RUN if FLUSH_CYCLES=0.
  - FLUSH: FLUSH_CYCLES cycles. Streams driven, no accumulation -> RUN.
  - RUN: exactly 2^LOG_WINDOW cycles. Streams driven; sample y each cycle -> DONE.
  - DONE: out_valid=1, result stable until out_ready. On the out_valid&out_ready cycle -> IDLE; in_ready rises the next cycle.
- dp_nrst is 1 in every state except CLEAR and reset.
- Streams and RNG:
  - 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every FLUSH/RUN cycle.
  - rA = LFSR[WIDTH-2:0]; rB = LFSR[15:17-WIDTH].
  - Operand bit = (mag > r); bit goes to the p channel if the operand is positive, the m channel if negative. The other channel is 0.
  - Streams are registered outputs, 0 in IDLE/CLEAR/DONE.
- Accumulation: sample y_p/y_m in RUN cycles only, including the first RUN cycle.
  - y_p&~y_m adds +1; y_m&~y_p adds -1; equal inputs add 0.
  - Width LOG_WINDOW+2 cannot overflow; range is ±2^LOG_WINDOW.
- Latency: accept edge to out_valid = 1 + FLUSH_CYCLES + 2^LOG_WINDOW cycles.
- Boundaries:
  - in_valid outside IDLE is ignored and operands are not relatched.
  - out_ready while out_valid=0 is ignored.
  - Reset mid-job discards the job; the next job starts from seed, so results are deterministic per operand pair.

Optional Feature:
- STOCH_SUB_CTRL_ABORT_EN: adds input port abort (1 bit).
  - abort=1 in CLEAR/FLUSH/RUN/DONE: next state CLEAR_ABORT (1 cycle, dp_nrst=0, streams=0, accumulator=0) -> IDLE.
  - out_valid drops immediately and no result is delivered. abort in IDLE has no effect.
  - Without the macro: no port, no CLEAR_ABORT state, jobs always complete.

Decomposition:
- Package stoch_ctrl_pkg holds:
  - FSM state enum.
  - LFSR width (16), tap mask, default seed.
  - Function for signed-to-sign/magnitude with clamp.
- One natural sub-module, stoch_lfsr16: load/enable inputs, 16-bit state output. Reusable by other stochastic controllers.

Test Plan:
- Datapath stub y_p=1, y_m=0, WIDTH=8, LOG_WINDOW=8, FLUSH_CYCLES=4:
  - result=+256.
  - out_valid exactly 261 cycles after accept.
  - dp_nrst low for exactly the CLEAR cycle.
- Stub y_p=y_m=1 -> result=0. Stub y_m=1, y_p=0 -> result=-256.
- a=0, b=0 -> all four streams 0 for the whole job. a=-128 -> a_m stream identical cycle-by-cycle to a=-127; a_p always 0.
- Backpressure: out_ready held 0 for 50 cycles -> out_valid and result stable, in_ready=0; in_valid pulses ignored; accept on the out_ready cycle, then in_ready=1.
- nRST=0 mid-RUN -> next cycle outputs at reset values. Rerunning the same operands gives an identical result and stream trace.
- With STOCH_SUB_CTRL_ABORT_EN, abort in cycle 10 of RUN -> one dp_nrst=0 cycle, IDLE two cycles later, no out_valid.
